medidor_hcsr04: RTL
===================

# medidor_hcsr04

HC-SR04 ultrasonic ranging front end for the sonar. On a `medir` request from the sonar control unit it issues the trigger pulse and times the echo. It converts the echo width to centimetres as three BCD digits and signals `pronto`. The BCD distance feeds the distance-digit path of the serial transmit sequence; `pronto` is the control unit's `pronto_medida`.

## Interface
- `TRIGGER_CYCLES`, 500: trigger high time in clocks (10 µs @ 50 MHz).
- `CM_CYCLES`, 2941: echo clocks per centimetre (58.82 µs @ 50 MHz).
- `TIMEOUT_CYCLES`, 1_500_000: max clocks from end of trigger to echo fall (30 ms).

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `medir` in 1: start request, level sampled in `inicial` only.
- `echo` in 1: sensor echo pin, asynchronous.
- `trigger` out 1: sensor trigger pin.
- `medida` out 12: BCD distance {centena, dezena, unidade}, held between measurements.
- `pronto` out 1: one-cycle pulse, `medida` valid.
- `timeout` out 1: last measurement timed out. Held until the next `preparacao`.
- `db_estado` out 4: current state code.

## Operation
- `echo` passes through a 2-FF synchronizer giving `echo_s`. All echo logic uses `echo_s`.
- FSM states and codes:
  - `inicial` 0:
    - `medir`=1 → `preparacao`.
  - `preparacao` 1:
    - Clears the trigger counter, timeout counter, cm tick counter, BCD accumulator and `timeout`.
    - Always → `envia_trigger`.
  - `envia_trigger` 2:
    - `trigger`=1 for exactly `TRIGGER_CYCLES` cycles.
    - Then → `espera_echo`.
  - `espera_echo` 3:
    - `echo_s`=1 → `mede_echo`.
    - Timeout counter reaching `TIMEOUT_CYCLES` → `armazena`, with timeout set.
  - `mede_echo` 4:
    - Each cycle with `echo_s`=1 increments the tick counter.
    - When the tick counter reaches `CM_CYCLES`-1 it wraps to 0 and increments the BCD accumulator.
    - `echo_s`=0 → `armazena`.
    - Timeout counter reaching `TIMEOUT_CYCLES` → `armazena`, with timeout set.
  - `armazena` 5:
    - Normal case: if remainder ≥ `CM_CYCLES`/2 (integer division), add 1 to the accumulator (rounding), then register `medida`.
    - Timeout case: `medida` ← 12'h999 and `timeout` ← 1.
    - Always → `final_medida`.
  - `final_medida` 6:
    - `pronto`=1.
    - Always → `inicial`.
  - Unused codes → `inicial`.
- Timeout counter runs in `espera_echo` and `mede_echo` combined, starting from entry to `espera_echo`.
- BCD accumulator saturates at 999. Increments and rounding at 999 leave it at 999.
- Echo high for N sampled cycles gives `medida` = BCD(N / `CM_CYCLES`), rounded up when N mod `CM_CYCLES` ≥ `CM_CYCLES`/2, capped at 999.
- `medir` is ignored outside `inicial`, so there are no queued requests.

## Timing
- Reset values:
  - `trigger`=0, `pronto`=0, `timeout`=0, `medida`=12'h000, `db_estado`=0.
  - State `inicial`; all counters 0.
  - `echo` synchronizer flops 0.
- `medir` high at edge k puts the FSM in `preparacao` at k+1. `trigger` rises at k+2 and stays high `TRIGGER_CYCLES` cycles.
- `echo` → `echo_s` latency is 2 clocks.
- `echo_s` fall → `armazena` next cycle → `pronto` pulse the following cycle. `medida` is already valid when `pronto`=1.
- `medida` and `timeout` change only in `armazena`, except that `preparacao` clears `timeout`.
- `pronto` is exactly one cycle per accepted request, including timeouts, so the control unit never hangs.
- Reset mid-operation:
  - `trigger` drops asynchronously and `medida` returns to 000.
  - No `pronto` is issued.
- `echo_s` already high on entry to `espera_echo` (stale echo): treated as echo start.

## Structure
- Shared package `sonar_pkg`:
  - state encoding constants (`inicial`…`final_medida`);
  - default values of `TRIGGER_CYCLES`, `CM_CYCLES` and `TIMEOUT_CYCLES`;
  - BCD saturation constant 12'h999.
- Counter widths are `$clog2` of the respective parameters.
- One sub-module, `contador_bcd_3dig`:
  - inputs `zera`, `conta`;
  - 12-bit BCD output;
  - saturates at 999.
- FSM, trigger/timeout/tick counters and the synchronizer stay in the top module.

## Test plan
- Reset, then idle 100 cycles → `trigger`=0, `pronto`=0, `timeout`=0, `medida`=12'h000, `db_estado`=0.
- `medir` 1-cycle pulse → `trigger` high exactly 500 cycles. A second `medir` pulse during the trigger is ignored, with a single `pronto` at the end.
- Echo high 29410 cycles → `medida`=12'h010, one `pronto` cycle, `timeout`=0.
- Rounding:
  - echo 2941·5+1469 cycles → 12'h005;
  - echo 2941·5+1470 cycles → 12'h006.
- Timeout and saturation:
  - No echo → after `TIMEOUT_CYCLES` from trigger fall, `medida`=12'h999, `timeout`=1, one `pronto`.
  - Next normal measurement clears `timeout`.
  - With `CM_CYCLES`=4 and `TIMEOUT_CYCLES`=10000, echo of 4200 cycles → 12'h999, `timeout`=0.
- Reset asserted mid-`mede_echo` → `trigger`=0, state 0, `medida`=000, no `pronto`. A subsequent measurement with echo 2941·42 cycles → 12'h042.

Source files
------------

// File: rtl/sonar_pkg.sv
// +----------------------------------------------------------------------+
// | sonar_pkg: shared state codes, default timings and BCD helpers.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARACAO    = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDE_ECHO     = 4'd4,
        ARMAZENA      = 4'd5,
        FINAL_MEDIDA  = 4'd6
    } estado_t;

    localparam int TRIGGER_CYCLES_DEF = 500;
    localparam int CM_CYCLES_DEF      = 2941;
    localparam int TIMEOUT_CYCLES_DEF = 1_500_000;

    localparam logic [11:0] BCD_MAX = 12'h999;

    // Three-digit BCD increment that sticks at 999.
    function automatic logic [11:0] bcd_incr(input logic [11:0] valor);
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] u;
        {c, d, u} = valor;
        if (valor == BCD_MAX) begin
            return valor;
        end
        if (u != 4'd9) begin
            u = u + 4'd1;
        end else begin
            u = 4'd0;
            if (d != 4'd9) begin
                d = d + 4'd1;
            end else begin
                d = 4'd0;
                c = c + 4'd1;
            end
        end
        return {c, d, u};
    endfunction

endpackage

`default_nettype wire

// File: rtl/medidor_hcsr04_contador_bcd_3dig.sv
// +----------------------------------------------------------------------+
// | contador_bcd_3dig: 3-digit BCD up counter, saturating at 999.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module contador_bcd_3dig
    import sonar_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        conta,
    output logic [11:0] valor
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor <= 12'h000;
        end else if (zera) begin
            valor <= 12'h000;
        end else if (conta) begin
            valor <= bcd_incr(valor);
        end
    end

endmodule

`default_nettype wire

// File: rtl/medidor_hcsr04.sv
// +----------------------------------------------------------------------+
// | medidor_hcsr04: HC-SR04 trigger/echo timing, result in BCD cm.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module medidor_hcsr04
    import sonar_pkg::*;
#(
    parameter int TRIGGER_CYCLES = TRIGGER_CYCLES_DEF,
    parameter int CM_CYCLES      = CM_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        timeout,
    output logic [3:0]  db_estado
);

    localparam int TRIG_W = $clog2(TRIGGER_CYCLES);
    localparam int TICK_W = $clog2(CM_CYCLES);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIGGER_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CM_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CM_CYCLES / 2);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    estado_t            estado;
    estado_t            proximo;
    logic               echo_meta;
    logic               echo_s;
    logic [TRIG_W-1:0]  cnt_trigger;
    logic [TICK_W-1:0]  cnt_tick;
    logic [TO_W-1:0]    cnt_timeout;
    logic               expirou;
    logic [11:0]        acumulado;
    logic               medindo;
    logic               fim_trigger;
    logic               fim_timeout;
    logic               por_timeout;
    logic               zera_bcd;
    logic               conta_bcd;

    assign medindo     = (estado == ESPERA_ECHO) || (estado == MEDE_ECHO);
    assign fim_trigger = (cnt_trigger == TRIG_LAST);
    assign fim_timeout = (cnt_timeout == TO_LAST);
    // An echo edge in the same cycle wins over the timeout.
    assign por_timeout = fim_timeout &&
                         (((estado == ESPERA_ECHO) && !echo_s) ||
                          ((estado == MEDE_ECHO) && echo_s));
    assign zera_bcd    = (estado == PREPARACAO);
    assign conta_bcd   = medindo && echo_s && (cnt_tick == TICK_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo   = estado;
        trigger   = 1'b0;
        pronto    = 1'b0;
        db_estado = estado;
        case (estado)
            INICIAL: begin
                if (medir) begin
                    proximo = PREPARACAO;
                end
            end
            PREPARACAO: proximo = ENVIA_TRIGGER;
            ENVIA_TRIGGER: begin
                trigger = 1'b1;
                if (fim_trigger) begin
                    proximo = ESPERA_ECHO;
                end
            end
            ESPERA_ECHO: begin
                if (echo_s) begin
                    proximo = MEDE_ECHO;
                end else if (fim_timeout) begin
                    proximo = ARMAZENA;
                end
            end
            MEDE_ECHO: begin
                if (!echo_s || fim_timeout) begin
                    proximo = ARMAZENA;
                end
            end
            ARMAZENA:     proximo = FINAL_MEDIDA;
            FINAL_MEDIDA: begin
                pronto  = 1'b1;
                proximo = INICIAL;
            end
            default:      proximo = INICIAL;
        endcase
    end

    // The espera_echo cycle that first sees echo_s also counts as echo time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_trigger <= '0;
            cnt_tick    <= '0;
            cnt_timeout <= '0;
        end else if (estado == PREPARACAO) begin
            cnt_trigger <= '0;
            cnt_tick    <= '0;
            cnt_timeout <= '0;
        end else if (estado == ENVIA_TRIGGER) begin
            cnt_trigger <= cnt_trigger + 1'b1;
        end else if (medindo) begin
            cnt_timeout <= cnt_timeout + 1'b1;
            if (echo_s) begin
                cnt_tick <= (cnt_tick == TICK_LAST) ? '0 : cnt_tick + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            expirou <= 1'b0;
            timeout <= 1'b0;
            medida  <= 12'h000;
        end else if (estado == PREPARACAO) begin
            expirou <= 1'b0;
            timeout <= 1'b0;
        end else if (por_timeout) begin
            expirou <= 1'b1;
        end else if (estado == ARMAZENA) begin
            if (expirou) begin
                medida  <= BCD_MAX;
                timeout <= 1'b1;
            end else if (cnt_tick >= TICK_HALF) begin
                medida  <= bcd_incr(acumulado);
            end else begin
                medida  <= acumulado;
            end
        end
    end

    contador_bcd_3dig u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera_bcd),
        .conta (conta_bcd),
        .valor (acumulado)
    );

endmodule

`default_nettype wire
